rmii_tx_arbiter: RTL
====================

Name: rmii_tx_arbiter

Overview:
- Round-robin scheduler that shares the single RMII transmit path (preamble/SFD/pad/FCS engine) between N frame sources.
- Grants one source at a time and forwards that source's contiguous dibit stream to the transmitter.
- Waits for the transmitter to finish the frame, including FCS, then enforces the 96-bit interpacket gap before the next grant.
- Sits between the packet builders and the transmitter, on the 50 MHz RMII clock domain.

Parameters:
- N_SRC, 4, number of requesters (2..8).
- IPG_CYCLES, 48, idle clks between end of transmitter output and next grant (96 bits / 2).
- MAX_DIBITS, 6000, maximum payload dibits forwarded per frame (1500 bytes).
- GRANT_TIMEOUT, 64, clks a granted source may take to raise valid (used only with the optional feature).

Ports:
- clk  in  1  50 MHz clock
- rst  in  1  reset
- req  in  N_SRC  per-source frame request, level
- src_valid  in  N_SRC  per-source dibit valid
- src_data  in  2*N_SRC  per-source dibit; source i on bits [2i+1:2i]
- gnt  out  N_SRC  one-hot grant
- tx_axiiv  out  1  dibit valid to transmitter
- tx_axiid  out  2  dibit to transmitter
- tx_axiov  in  1  transmitter output valid (line busy)
- busy  out  1  arbiter not in IDLE
- frame_done  out  1  one-clk pulse at end of IPG
- overflow  out  1  one-clk pulse when MAX_DIBITS is exceeded
- cur_src  out  3  index of last granted source

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: gnt=0, tx_axiiv=0, tx_axiid=0, busy=0, frame_done=0, overflow=0, cur_src=N_SRC-1, all counters 0, state IDLE.
- Reset mid-frame: outputs drop the next clk; the transmitter sees valid fall. No recovery beyond that.
- States:
  - IDLE: if any req bit is set, pick the first set req searching from (cur_src+1) mod N_SRC with wrap. Then set gnt one-hot, load cur_src, clear dib_cnt, clear started. Go to GRANT. Grant is issued the clk after req is seen.
  - GRANT:
    - Register the stream: tx_axiiv <= src_valid[cur_src] & ~capped; tx_axiid <= src_data[cur_src]. Latency is exactly 1 clk.
    - On the first valid, set started.
    - While valid and not capped, increment dib_cnt. When dib_cnt reaches MAX_DIBITS, set capped and pulse overflow; further dibits are dropped and tx_axiiv is held 0.
    - When started and src_valid[cur_src]==0: drop gnt, set tx_axiiv=0, go to DRAIN.
    - Sources must stream valid contiguously; the first low after started ends the frame.
    - req deassertion during GRANT is ignored.
  - DRAIN:
    - Set seen_busy when tx_axiov==1.
    - Once seen_busy==1 and tx_axiov==0, load the IPG counter with IPG_CYCLES-1 and go to IPG.
    - If tx_axiov never rises, the arbiter stays in DRAIN. This is legal only with an inactive transmitter and is not recovered.
  - IPG:
    - Count down. At 0, pulse frame_done and go to IDLE.
    - Arbitration for the next grant happens in IDLE on the following clk.
- Fairness: the winning source becomes lowest priority. A source with req held continuously transmits at most once per N_SRC frames while others request.
- Simultaneous reqs: resolved only by the rotating pointer. After reset, source 0 wins.
- gnt and tx_axiiv are never asserted in DRAIN or IPG.
- busy = (state != IDLE).
- src_valid from ungranted sources is ignored.

Optional Feature:
- Macro: TX_ARB_TIMEOUT_EN.
- Defined: a counter runs in GRANT while started==0.
  - If the counter reaches GRANT_TIMEOUT, revoke gnt and go directly to IPG. No frame was sent, so DRAIN is skipped.
  - A sticky timeout_err output is added, cleared only by rst.
  - cur_src still advances past the stalled source.
- Undefined: no counter and no timeout_err port. A granted source may wait indefinitely before raising valid.

Decomposition:
- Package rmii_tx_pkg holds:
  - state enum {IDLE, GRANT, DRAIN, IPG};
  - the RMII_IPG_DIBITS=48 constant;
  - the MAX_FRAME_DIBITS=6000 constant;
  - the dibit_t typedef (logic [1:0]).
- One sub-module, rr_pick: combinational round-robin selector taking req and pointer, returning a one-hot grant and its index. Reusable for the receive-side fan-out.

Test Plan:
- Reset, req=4'b0001, source 0 streams 60 dibits of 2'b11 -> gnt[0] the clk after req; tx_axiid=2'b11 valid for exactly 60 clks, each 1 clk after src_valid; gnt drops when valid falls.
- req=4'b1111 held, each frame 20 dibits, model transmitter -> grant order 0,1,2,3,0; frame_done 4 pulses.
- Model drives tx_axiov high for 300 clks after the frame -> next gnt no earlier than 300+48+1 clks after the frame's first tx_axiov high.
- Source streams 6005 dibits -> exactly 6000 forwarded; overflow pulses once; arbiter returns to DRAIN when valid falls.
- rst asserted mid-GRANT at dibit 10 -> next clk gnt=0, tx_axiiv=0, busy=0; after release, source 0 has priority again.
- With TX_ARB_TIMEOUT_EN, gnt[2] issued but source 2 never raises valid -> gnt revoked after 64 clks; timeout_err=1; next request goes to source 3.

Source files
------------

// File: rtl/rmii_tx_pkg.sv
// Shared types and constants for the RMII transmit-side arbiter and its helpers.
package rmii_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAIN,
        IPG
    } arb_state_t;

    localparam int RMII_IPG_DIBITS  = 48;
    localparam int MAX_FRAME_DIBITS = 6000;

    typedef logic [1:0] dibit_t;

endpackage

// File: rtl/rmii_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after ptr, with wrap.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // ptr itself is checked last, so the previous winner has lowest priority
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                        = 1'b1;
                idx                        = IDX_W'((int'(ptr) + k) % N);
                gnt[(int'(ptr) + k) % N]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rmii_tx_arbiter.sv
// Round-robin arbiter sharing one RMII transmitter between N_SRC frame sources.
// Optional grant timeout (adds timeout_err) is enabled by defining TX_ARB_TIMEOUT_EN.
module rmii_tx_arbiter
    import rmii_tx_pkg::*;
#(
    parameter int N_SRC         = 4,
    parameter int IPG_CYCLES    = RMII_IPG_DIBITS,
`ifdef TX_ARB_TIMEOUT_EN
    parameter int GRANT_TIMEOUT = 64,
`endif
    parameter int MAX_DIBITS    = MAX_FRAME_DIBITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   req,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [2*N_SRC-1:0] src_data,
    output logic [N_SRC-1:0]   gnt,
    output logic               tx_axiiv,
    output logic [1:0]         tx_axiid,
    input  logic               tx_axiov,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow,
`ifdef TX_ARB_TIMEOUT_EN
    output logic               timeout_err,
`endif
    output logic [2:0]         cur_src
);

    localparam int CNT_W = $clog2(MAX_DIBITS + 1);
    localparam int IPG_W = $clog2(IPG_CYCLES + 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] dib_cnt;
    logic [IPG_W-1:0] ipg_cnt;
    logic             started, capped, seen_busy;
    logic             sv;
    dibit_t           sd;
    logic             at_cap;
    logic             timeout_hit;
    logic [N_SRC-1:0] pick_gnt;
    logic [2:0]       pick_idx;
    logic             pick_any;

    rr_pick #(
        .N     (N_SRC),
        .IDX_W (3)
    ) u_pick (
        .req (req),
        .ptr (cur_src),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Only the granted source's lane is observed
    always_comb begin
        sv = 1'b0;
        sd = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cur_src == 3'(i)) begin
                sv = src_valid[i];
                sd = src_data[2*i +: 2];
            end
        end
    end

    assign at_cap = (dib_cnt == CNT_W'(MAX_DIBITS));
    assign busy   = (state != IDLE);

`ifdef TX_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(GRANT_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    assign timeout_hit = (state == GRANT) && !started && !sv &&
                         (to_cnt == TO_W'(GRANT_TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = GRANT;
            GRANT: begin
                if (started && !sv)  state_nxt = DRAIN;
                else if (timeout_hit) state_nxt = IPG;
            end
            DRAIN:   if (seen_busy && !tx_axiov) state_nxt = IPG;
            IPG:     if (ipg_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            cur_src    <= 3'(N_SRC - 1);
            dib_cnt    <= '0;
            ipg_cnt    <= '0;
            started    <= 1'b0;
            capped     <= 1'b0;
            seen_busy  <= 1'b0;
            tx_axiiv   <= 1'b0;
            tx_axiid   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt       <= pick_gnt;
                        cur_src   <= pick_idx;
                        dib_cnt   <= '0;
                        started   <= 1'b0;
                        capped    <= 1'b0;
                        seen_busy <= 1'b0;
                    end
                end
                GRANT: begin
                    // The dibit that would exceed the cap is dropped, not forwarded
                    tx_axiiv <= sv & ~capped & ~at_cap;
                    tx_axiid <= sd;
                    if (sv) started <= 1'b1;
                    if (sv && !capped) begin
                        if (at_cap) begin
                            capped   <= 1'b1;
                            overflow <= 1'b1;
                        end else begin
                            dib_cnt <= dib_cnt + 1'b1;
                        end
                    end
                    if (started && !sv) gnt <= '0;
                    if (timeout_hit) begin
                        gnt     <= '0;
                        ipg_cnt <= IPG_W'(IPG_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (tx_axiov) seen_busy <= 1'b1;
                    if (seen_busy && !tx_axiov) ipg_cnt <= IPG_W'(IPG_CYCLES - 1);
                end
                IPG: begin
                    if (ipg_cnt == '0) frame_done <= 1'b1;
                    else               ipg_cnt    <= ipg_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef TX_ARB_TIMEOUT_EN
    // Wait counter runs only before the first valid of a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE) to_cnt <= '0;
            else if (state == GRANT && !started && !sv) to_cnt <= to_cnt + 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`endif

endmodule
